// File: rtl/axi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_responder_pkg
// Brief    : AXI burst and response encodings shared by the memory responder.
// Revision : 1.0
// ============================================================================
package axi_mem_responder_pkg;

   typedef enum logic [1:0] {
      FIXED    = 2'd0,
      INCR     = 2'd1,
      WRAP     = 2'd2,
      RESERVED = 2'd3
   } t_burst;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } t_resp;

   // Which request kind wins when AR and AW arrive together
   typedef enum logic {
      PRIO_WR = 1'b0,
      PRIO_RD = 1'b1
   } t_prio;

   localparam int c_AXI_LEN_W = 8;

endpackage
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_responder
// Brief    : AXI slave serialising INCR read/write bursts onto one single-port RAM.
// Revision : 1.0
// ============================================================================
module axi_mem_responder
   import axi_mem_responder_pkg::*;
#(
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 32,
   parameter int MEM_DEPTH = 4096
) (
   input  logic                         i_clk,
   input  logic                         i_areset_n,
   // read address / data
   input  logic [ADDR_SIZE-1:0]         i_axi_araddr,
   input  logic [c_AXI_LEN_W-1:0]       i_axi_arlen,
   input  logic [2:0]                   i_axi_arsize,
   input  t_burst                       i_axi_arburst,
   input  logic                         i_axi_arvalid,
   output logic                         o_axi_arready,
   output logic [DATA_SIZE-1:0]         o_axi_rdata,
   output t_resp                        o_axi_rresp,
   output logic                         o_axi_rlast,
   output logic                         o_axi_rvalid,
   input  logic                         i_axi_rready,
   // write address / data / response
   input  logic [ADDR_SIZE-1:0]         i_axi_awaddr,
   input  logic [c_AXI_LEN_W-1:0]       i_axi_awlen,
   input  logic [2:0]                   i_axi_awsize,
   input  t_burst                       i_axi_awburst,
   input  logic                         i_axi_awvalid,
   output logic                         o_axi_awready,
   input  logic [DATA_SIZE-1:0]         i_axi_wdata,
   input  logic [DATA_SIZE/8-1:0]       i_axi_wstrb,
   input  logic                         i_axi_wlast,
   input  logic                         i_axi_wvalid,
   output logic                         o_axi_wready,
   output t_resp                        o_axi_bresp,
   output logic                         o_axi_bvalid,
   input  logic                         i_axi_bready,
   // RAM port
   output logic [$clog2(MEM_DEPTH)-1:0] o_mem_addr,
   output logic                         o_mem_en,
   output logic [DATA_SIZE/8-1:0]       o_mem_we,
   output logic [DATA_SIZE-1:0]         o_mem_wdata,
   input  logic [DATA_SIZE-1:0]         i_mem_rdata
);

   localparam int c_MEM_AW = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_FETCH = 3'd1,
      RD_DATA  = 3'd2,
      WR_DATA  = 3'd3,
      WR_RESP  = 3'd4
   } t_state;

   t_state                  r_state;
   t_state                  w_state_nxt;
   t_prio                   r_prio;
   logic [c_MEM_AW-1:0]     r_addr;
   logic [c_AXI_LEN_W-1:0]  r_len;
   logic [c_AXI_LEN_W-1:0]  r_cnt;
   logic [DATA_SIZE-1:0]    r_rdata;
   logic                    r_hold;

   logic w_ar_win;
   logic w_aw_win;
   logic w_rd_last;

   // Burst type, size and address bits outside the RAM window carry no meaning here
   logic w_unused;
   assign w_unused = ^{i_axi_araddr[ADDR_SIZE-1:c_MEM_AW+2], i_axi_araddr[1:0],
                       i_axi_awaddr[ADDR_SIZE-1:c_MEM_AW+2], i_axi_awaddr[1:0],
                       i_axi_arsize, i_axi_awsize, i_axi_arburst, i_axi_awburst};

   assign w_ar_win  = i_axi_arvalid && (!i_axi_awvalid || (r_prio == PRIO_RD));
   assign w_aw_win  = i_axi_awvalid && (!i_axi_arvalid || (r_prio == PRIO_WR));
   assign w_rd_last = (r_cnt == r_len);

   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = i_axi_wdata;
   // First RD_DATA cycle forwards the RAM output; later cycles replay the captured copy
   assign o_axi_rdata = r_hold ? r_rdata : i_mem_rdata;
   assign o_axi_rlast = w_rd_last;
   assign o_axi_rresp = OKAY;
   assign o_axi_bresp = OKAY;

   always_comb begin
      w_state_nxt   = r_state;
      o_axi_arready = 1'b0;
      o_axi_awready = 1'b0;
      o_axi_rvalid  = 1'b0;
      o_axi_wready  = 1'b0;
      o_axi_bvalid  = 1'b0;
      o_mem_en      = 1'b0;
      o_mem_we      = '0;
      case (r_state)
         IDLE: begin
            o_axi_arready = w_ar_win;
            o_axi_awready = w_aw_win;
            if (w_ar_win)      w_state_nxt = RD_FETCH;
            else if (w_aw_win) w_state_nxt = WR_DATA;
         end
         RD_FETCH: begin
            o_mem_en    = 1'b1;
            w_state_nxt = RD_DATA;
         end
         RD_DATA: begin
            o_axi_rvalid = 1'b1;
            if (i_axi_rready) w_state_nxt = w_rd_last ? IDLE : RD_FETCH;
         end
         WR_DATA: begin
            o_axi_wready = 1'b1;
            if (i_axi_wvalid) begin
               o_mem_en = 1'b1;
               o_mem_we = i_axi_wstrb;
               if (i_axi_wlast) w_state_nxt = WR_RESP;
            end
         end
         WR_RESP: begin
            o_axi_bvalid = 1'b1;
            if (i_axi_bready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state <= IDLE;
         r_prio  <= PRIO_WR;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_hold  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_ar_win) begin
                  r_addr <= i_axi_araddr[c_MEM_AW+1:2];
                  r_len  <= i_axi_arlen;
                  r_cnt  <= '0;
                  r_prio <= PRIO_WR;
               end else if (w_aw_win) begin
                  r_addr <= i_axi_awaddr[c_MEM_AW+1:2];
                  r_len  <= i_axi_awlen;
                  r_prio <= PRIO_RD;
               end
            end
            RD_FETCH: r_hold <= 1'b0;
            RD_DATA: begin
               if (!r_hold) begin
                  r_rdata <= i_mem_rdata;
                  r_hold  <= 1'b1;
               end
               if (i_axi_rready && !w_rd_last) begin
                  r_addr <= r_addr + c_MEM_AW'(1);
                  r_cnt  <= r_cnt + c_AXI_LEN_W'(1);
               end
            end
            WR_DATA: begin
               if (i_axi_wvalid) r_addr <= r_addr + c_MEM_AW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/sp_bram.sv
`default_nettype none
// ============================================================================
// Module   : sp_bram
// Brief    : Single-port word RAM model, byte enables, 1-cycle read latency.
// Revision : 1.0
// ============================================================================
module sp_bram #(
   parameter int DEPTH = 4096,
   parameter int DW    = 32
) (
   input  logic                     i_clk,
   input  logic                     i_en,
   input  logic [DW/8-1:0]          i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [DW-1:0]            i_wdata,
   output logic [DW-1:0]            o_rdata
);
   logic [DW-1:0] mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      o_rdata = '0;
   end

   always @(posedge i_clk) begin
      if (i_en) begin
         if (i_we == '0) o_rdata <= mem[i_addr];
         for (int b = 0; b < DW/8; b++)
            if (i_we[b]) mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_responder
// Brief    : Directed, table-driven bench for axi_mem_responder with RAM model.
// Revision : 1.0
// ============================================================================
module tb_axi_mem_responder;
   import axi_mem_responder_pkg::*;

   localparam int ADDR_SIZE = 32;
   localparam int DATA_SIZE = 32;
   localparam int MEM_DEPTH = 4096;
   localparam int MAW       = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic [7:0]  arlen = '0, awlen = '0;
   logic [3:0]  wstrb = '0;
   logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
   logic        rready = 1'b0, bready = 1'b0;
   logic        arready, awready, wready, rvalid, rlast, bvalid;
   logic [31:0] rdata;
   t_resp       rresp, bresp;
   logic [MAW-1:0] mem_addr;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata, mem_rdata;

   axi_mem_responder #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE), .MEM_DEPTH(MEM_DEPTH)) u_dut (
      .i_clk(clk), .i_areset_n(rst_n),
      .i_axi_araddr(araddr), .i_axi_arlen(arlen), .i_axi_arsize(3'd2), .i_axi_arburst(INCR),
      .i_axi_arvalid(arvalid), .o_axi_arready(arready),
      .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rlast(rlast), .o_axi_rvalid(rvalid),
      .i_axi_rready(rready),
      .i_axi_awaddr(awaddr), .i_axi_awlen(awlen), .i_axi_awsize(3'd2), .i_axi_awburst(INCR),
      .i_axi_awvalid(awvalid), .o_axi_awready(awready),
      .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wlast(wlast), .i_axi_wvalid(wvalid),
      .o_axi_wready(wready),
      .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
      .o_mem_addr(mem_addr), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   sp_bram #(.DEPTH(MEM_DEPTH), .DW(DATA_SIZE)) u_ram (
      .i_clk(clk), .i_en(mem_en), .i_we(mem_we), .i_addr(mem_addr),
      .i_wdata(mem_wdata), .o_rdata(mem_rdata)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      bit              wr;
      bit              stall;
      logic [31:0]     addr;
      logic [7:0]      len;
      logic [3:0]      strb;
      logic [3:0][31:0] data;
      logic [3:0][31:0] exp;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk(input bit wr, input bit stall, input logic [31:0] addr,
                               input logic [7:0] len, input logic [3:0] strb,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
      vec_t v;
      v.wr = wr; v.stall = stall; v.addr = addr; v.len = len; v.strb = strb;
      v.data = {d3, d2, d1, d0};
      v.exp  = {e3, e2, e1, e0};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called in the low clock phase; returns in the low phase after the B handshake
   task automatic do_write(input vec_t v);
      int t;
      int idx;
      awaddr = v.addr; awlen = v.len; awvalid = 1'b1;
      t = 0; #1;
      while (!awready && t < 50) begin @(negedge clk); #1; t++; end
      check("aw_accept", awready, 1);
      @(negedge clk); awvalid = 1'b0;
      for (int i = 0; i <= int'(v.len); i++) begin
         wdata = v.data[i]; wstrb = v.strb; wlast = (i == int'(v.len)); wvalid = 1'b1;
         t = 0; #1;
         while (!wready && t < 50) begin @(negedge clk); #1; t++; end
         check("w_accept", wready, 1);
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      #1;
      check("b_valid_after_last_w", bvalid, 1);
      check("b_resp", bresp, OKAY);
      @(negedge clk); bready = 1'b0;
      #1;
      check("b_single", bvalid, 0);
      for (int i = 0; i <= int'(v.len); i++) begin
         idx = (int'(v.addr[MAW+1:2]) + i) % MEM_DEPTH;
         check("ram_word", u_ram.mem[idx], v.exp[i]);
      end
   endtask

   task automatic do_read(input vec_t v);
      int t, hs, k;
      bit seen, was_stalled;
      logic [31:0] held;
      araddr = v.addr; arlen = v.len; arvalid = 1'b1;
      t = 0; #1;
      while (!arready && t < 50) begin @(negedge clk); #1; t++; end
      check("ar_accept", arready, 1);
      hs = cyc;
      @(negedge clk); arvalid = 1'b0;
      k = 0; seen = 1'b0; was_stalled = 1'b0; held = '0; t = 0;
      while (k <= int'(v.len) && t < 200) begin
         rready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (was_stalled) check("r_stall_valid", rvalid, 1);
         if (rvalid) begin
            if (!seen) begin
               seen = 1'b1;
               check("r_first_latency", cyc - hs, 2);
            end
            if (was_stalled) check("r_stall_data", rdata, held);
            if (rready) begin
               check("r_data", rdata, v.exp[k]);
               check("r_last", rlast, (k == int'(v.len)));
               check("r_resp", rresp, OKAY);
               k++;
               was_stalled = 1'b0;
            end else begin
               was_stalled = 1'b1;
               held = rdata;
            end
         end
         @(negedge clk); t++;
      end
      rready = 1'b0;
      check("r_beat_count", k, int'(v.len) + 1);
      #1;
      check("r_no_extra", rvalid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int idle_bad;
      vec_t va, vb, vr;

      vecs[0] = mk(1, 0, 32'h40,    3, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                                            32'hA0, 32'hA1, 32'hA2, 32'hA3);
      vecs[1] = mk(0, 1, 32'h40,    3, 4'hF, 0, 0, 0, 0,
                                            32'hA0, 32'hA1, 32'hA2, 32'hA3);
      vecs[2] = mk(1, 0, 32'h40,    0, 4'b0100, 32'h00FF0000, 0, 0, 0,
                                            32'h00FF00A0, 0, 0, 0);
      vecs[3] = mk(0, 0, 32'h40,    0, 4'hF, 0, 0, 0, 0,
                                            32'h00FF00A0, 0, 0, 0);
      vecs[4] = mk(1, 0, 32'h3FF8,  3, 4'hF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                            32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      vecs[5] = mk(0, 1, 32'h3FF8,  3, 4'hF, 0, 0, 0, 0,
                                            32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      vecs[6] = mk(1, 0, 32'h10080, 1, 4'hF, 32'h55555555, 32'h66666666, 0, 0,
                                            32'h55555555, 32'h66666666, 0, 0);
      vecs[7] = mk(0, 0, 32'h80,    1, 4'hF, 0, 0, 0, 0,
                                            32'h55555555, 32'h66666666, 0, 0);

      // Reset and idle quiet period
      repeat (3) @(negedge clk);
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_ready", {arready, awready, wready}, 3'b000);
      @(negedge clk); rst_n = 1'b1;
      idle_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (arready || awready || rvalid || bvalid || mem_en || wready) idle_bad++;
      end
      check("idle_quiet", idle_bad, 0);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].wr) do_write(vecs[i]);
         else            do_read(vecs[i]);
      end

      // Simultaneous AR/AW: write, read, write, read
      va = mk(1, 0, 32'h48, 0, 4'hF, 32'hBEEF0001, 0, 0, 0, 32'hBEEF0001, 0, 0, 0);
      vb = mk(1, 0, 32'h4C, 0, 4'hF, 32'hBEEF0002, 0, 0, 0, 32'hBEEF0002, 0, 0, 0);
      vr = mk(0, 0, 32'h40, 0, 4'hF, 0, 0, 0, 0, 32'h00FF00A0, 0, 0, 0);
      araddr = 32'h40; arlen = 8'd0; arvalid = 1'b1;
      awaddr = 32'h48; awlen = 8'd0; awvalid = 1'b1;
      #1;
      check("arb1_ready", {arready, awready}, 2'b01);
      do_write(va);
      awaddr = 32'h4C; awvalid = 1'b1;
      #1;
      check("arb2_ready", {arready, awready}, 2'b10);
      do_read(vr);
      araddr = 32'h40; arvalid = 1'b1;
      #1;
      check("arb3_ready", {arready, awready}, 2'b01);
      do_write(vb);
      do_read(vr);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
